// File: rtl/bus_sequencer_if.sv
// Signal bundle shared by the bus sequencer, its CPU/DMA requesters and the memory.
// slave is the sequencer's view; master is the requester/memory side.
interface bus_sequencer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_cpu_req;
  logic          i_cpu_we;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic          o_cpu_ack;
  logic [DW-1:0] o_cpu_rdata;

  logic          i_dma_req;
  logic          i_dma_we;
  logic [AW-1:0] i_dma_addr;
  logic [DW-1:0] i_dma_wdata;
  logic          o_dma_ack;
  logic [DW-1:0] o_dma_rdata;

  logic          o_bus_clk;
  logic          o_bus_we;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_data;
  logic [DW-1:0] i_bus_data;
  logic          i_bus_data_ready;

  logic          o_busy;
  logic          o_owner;
  logic          o_timeout;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_ack, o_cpu_rdata,
    input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
    output o_dma_ack, o_dma_rdata,
    output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
    input  i_bus_data, i_bus_data_ready,
    output o_busy, o_owner, o_timeout
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_ack, o_cpu_rdata,
    output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
    input  o_dma_ack, o_dma_rdata,
    input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
    output i_bus_data, i_bus_data_ready,
    input  o_busy, o_owner, o_timeout
  );
endinterface

// File: rtl/bus_sequencer.sv
// Round-robin CPU/DMA arbiter driving a single strobe-based memory bus, one transaction
// at a time; reads wait for data-ready or abort after TIMEOUT_CYCLES wait cycles.
module bus_sequencer #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            i_clk,
  input logic            i_rst,
  bus_sequencer_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReadWait, StWrite, StRelease} state_e;

  state_e          state_q, state_d;
  logic            last_dma_q, last_dma_d;
  logic            owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            bus_clk_q, bus_clk_d;
  logic            bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_data_q, bus_data_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            dma_ack_q, dma_ack_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic            timeout_q, timeout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            grant_dma;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            rd_done;
  logic [DW-1:0]   rd_val;

  // A tie goes to whichever port was not granted last.
  assign grant_dma = bus.i_dma_req & (~bus.i_cpu_req | ~last_dma_q);
  assign sel_we    = grant_dma ? bus.i_dma_we    : bus.i_cpu_we;
  assign sel_addr  = grant_dma ? bus.i_dma_addr  : bus.i_cpu_addr;
  assign sel_wdata = grant_dma ? bus.i_dma_wdata : bus.i_cpu_wdata;

  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    bus_clk_d   = bus_clk_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_data_d  = bus_data_q;
    cpu_ack_d   = cpu_ack_q;
    dma_ack_d   = dma_ack_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    rd_done     = 1'b0;
    rd_val      = '0;

    case (state_q)
      StIdle: begin
        if (bus.i_cpu_req | bus.i_dma_req) begin
          owner_d    = grant_dma;
          last_dma_d = grant_dma;
          busy_d     = 1'b1;
          bus_clk_d  = 1'b1;
          bus_addr_d = sel_addr;
          bus_we_d   = sel_we;
          cnt_d      = '0;
          if (sel_we) begin
            bus_data_d = sel_wdata;
            state_d    = StWrite;
          end else begin
            state_d    = StReadWait;
          end
        end
      end

      StWrite: begin
        bus_clk_d  = 1'b0;
        bus_we_d   = 1'b0;
        bus_data_d = '0;
        cpu_ack_d  = ~owner_q;
        dma_ack_d  = owner_q;
        state_d    = StRelease;
      end

      StReadWait: begin
        // Ready takes priority over an expiring timeout in the same cycle.
        if (bus.i_bus_data_ready) begin
          rd_done = 1'b1;
          rd_val  = bus.i_bus_data;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
          rd_done   = 1'b1;
          rd_val    = '1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (rd_done) begin
          bus_clk_d = 1'b0;
          state_d   = StRelease;
          if (owner_q) begin
            dma_ack_d   = 1'b1;
            dma_rdata_d = rd_val;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = rd_val;
          end
        end
      end

      StRelease: begin
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        timeout_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      last_dma_q  <= 1'b1;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      bus_clk_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      bus_clk_q   <= bus_clk_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o_cpu_ack   = cpu_ack_q;
  assign bus.o_cpu_rdata = cpu_rdata_q;
  assign bus.o_dma_ack   = dma_ack_q;
  assign bus.o_dma_rdata = dma_rdata_q;
  assign bus.o_bus_clk   = bus_clk_q;
  assign bus.o_bus_we    = bus_we_q;
  assign bus.o_bus_addr  = bus_addr_q;
  assign bus.o_bus_data  = bus_data_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_owner     = owner_q;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed transaction table, reset-abort sequence,
// then randomized traffic predicted by a transaction-level round-robin model.
module tb_bus_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          TO = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  bus_sequencer #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    int            delay;      // wait cycles before ready, for the winner's read
    logic [DW-1:0] rd_data;
    logic          exp_owner;
    int            exp_lat;    // cycles from strobe to ack
    logic [DW-1:0] exp_cpu_rdata;
    logic [DW-1:0] exp_dma_rdata;
    logic          exp_to;
  } txn_t;

  logic [AW-1:0] hold_addr;

  function automatic txn_t mk(input logic cr, input logic cw, input logic [AW-1:0] ca,
                              input logic [DW-1:0] cd, input logic dr, input logic dw,
                              input logic [AW-1:0] da, input logic [DW-1:0] dd, input int dly,
                              input logic [DW-1:0] rdd, input logic eo, input int lat,
                              input logic [DW-1:0] ecr, input logic [DW-1:0] edr,
                              input logic eto);
    txn_t t;
    t.cpu_req = cr; t.cpu_we = cw; t.cpu_addr = ca; t.cpu_wdata = cd;
    t.dma_req = dr; t.dma_we = dw; t.dma_addr = da; t.dma_wdata = dd;
    t.delay = dly; t.rd_data = rdd; t.exp_owner = eo; t.exp_lat = lat;
    t.exp_cpu_rdata = ecr; t.exp_dma_rdata = edr; t.exp_to = eto;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle();
    chk("idle_ctl", {60'd0, bus.o_busy, bus.o_cpu_ack, bus.o_dma_ack, bus.o_timeout}, 64'd0);
    chk("idle_bus", {62'd0, bus.o_bus_clk, bus.o_bus_we}, 64'd0);
    chk("idle_addr_hold", {32'd0, bus.o_bus_addr}, {32'd0, hold_addr});
    chk("idle_data", {32'd0, bus.o_bus_data}, 64'd0);
  endtask

  // Starts and ends on the falling edge of an idle cycle.
  task automatic do_txn(input txn_t t);
    logic          own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    own_we    = t.exp_owner ? t.dma_we    : t.cpu_we;
    own_addr  = t.exp_owner ? t.dma_addr  : t.cpu_addr;
    own_wdata = t.exp_owner ? t.dma_wdata : t.cpu_wdata;
    chk_idle();
    bus.i_cpu_req = t.cpu_req; bus.i_cpu_we = t.cpu_we;
    bus.i_cpu_addr = t.cpu_addr; bus.i_cpu_wdata = t.cpu_wdata;
    bus.i_dma_req = t.dma_req; bus.i_dma_we = t.dma_we;
    bus.i_dma_addr = t.dma_addr; bus.i_dma_wdata = t.dma_wdata;
    // Ready held high in idle must be ignored.
    bus.i_bus_data_ready = 1'b1;
    bus.i_bus_data = 32'hBAD0_0000 | DW'($urandom_range(0, 65535));
    @(negedge clk);
    chk("strobe_ctl", {57'd0, bus.o_bus_clk, bus.o_busy, bus.o_owner, bus.o_bus_we,
        bus.o_cpu_ack, bus.o_dma_ack, bus.o_timeout},
        {57'd0, 1'b1, 1'b1, t.exp_owner, own_we, 3'b000});
    chk("strobe_addr", {32'd0, bus.o_bus_addr}, {32'd0, own_addr});
    if (own_we) chk("strobe_data", {32'd0, bus.o_bus_data}, {32'd0, own_wdata});
    for (int k = 0; k < t.exp_lat; k++) begin
      if (k > 0)
        chk("wait_ctl", {59'd0, bus.o_bus_clk, bus.o_busy, bus.o_cpu_ack, bus.o_dma_ack,
            bus.o_timeout}, {59'd0, 5'b11000});
      if (own_we) begin
        bus.i_bus_data_ready = 1'($urandom_range(0, 1));
        bus.i_bus_data = $urandom;
      end else begin
        bus.i_bus_data_ready = (k == t.delay);
        bus.i_bus_data = (k == t.delay) ? t.rd_data : $urandom;
      end
      @(negedge clk);
    end
    bus.i_bus_data_ready = 1'b0;
    chk("ack_ctl", {59'd0, bus.o_cpu_ack, bus.o_dma_ack, bus.o_timeout, bus.o_bus_clk,
        bus.o_busy}, {59'd0, !t.exp_owner, t.exp_owner, t.exp_to, 1'b0, 1'b1});
    chk("ack_owner", {63'd0, bus.o_owner}, {63'd0, t.exp_owner});
    chk("cpu_rdata", {32'd0, bus.o_cpu_rdata}, {32'd0, t.exp_cpu_rdata});
    chk("dma_rdata", {32'd0, bus.o_dma_rdata}, {32'd0, t.exp_dma_rdata});
    if (own_we) chk("wr_clear", {31'd0, bus.o_bus_we, bus.o_bus_data}, 64'd0);
    if (t.exp_owner) bus.i_dma_req = 1'b0;
    else bus.i_cpu_req = 1'b0;
    hold_addr = own_addr;
    @(negedge clk);
  endtask

  txn_t          tbl[7];
  txn_t          t;
  logic          m_last;
  logic [DW-1:0] m_rd[2];
  logic          pend[2];
  logic          pwe[2];
  logic [AW-1:0] pa[2];
  logic [DW-1:0] pd[2];
  logic          w;
  int            dly;
  logic [DW-1:0] rdd;
  int            lat;
  logic          eto;

  initial begin
    checks = 0;
    errors = 0;
    hold_addr = '0;
    //             cr cw addr      wdata      dr dw addr      wdata dly rd_data    own lat cpu_rd     dma_rd     to
    tbl[0] = mk(1, 1, 32'h1234, 32'hA5, 0, 0, 32'h0,   32'h0,  0, 32'h0,        0, 1, 32'h0,       32'h0,        0);
    tbl[1] = mk(0, 0, 32'h0,    32'h0,  1, 0, 32'h200, 32'h0,  3, 32'hDEADBEEF, 1, 4, 32'h0,       32'hDEADBEEF, 0);
    tbl[2] = mk(1, 0, 32'h10,   32'h0,  1, 1, 32'h20,  32'h22, 0, 32'h11111111, 0, 1, 32'h11111111, 32'hDEADBEEF, 0);
    tbl[3] = mk(1, 0, 32'h30,   32'h0,  1, 1, 32'h20,  32'h22, 0, 32'h0,        1, 1, 32'h11111111, 32'hDEADBEEF, 0);
    tbl[4] = mk(1, 0, 32'h30,   32'h0,  1, 0, 32'h44,  32'h0,  7, 32'h33333333, 0, 4, 32'hFFFFFFFF, 32'hDEADBEEF, 1);
    tbl[5] = mk(1, 1, 32'h50,   32'h5,  1, 0, 32'h44,  32'h0,  3, 32'h55555555, 1, 4, 32'hFFFFFFFF, 32'h55555555, 0);
    tbl[6] = mk(1, 1, 32'h50,   32'h5,  0, 0, 32'h0,   32'h0,  0, 32'h0,        0, 1, 32'hFFFFFFFF, 32'h55555555, 0);

    rst = 1'b1;
    bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
    bus.i_dma_req = 1'b0; bus.i_dma_we = 1'b0; bus.i_dma_addr = '0; bus.i_dma_wdata = '0;
    bus.i_bus_data = '0; bus.i_bus_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {57'd0, bus.o_bus_clk, bus.o_bus_we, bus.o_busy, bus.o_owner,
        bus.o_timeout, bus.o_cpu_ack, bus.o_dma_ack}, 64'd0);
    chk("reset_rdata", {bus.o_cpu_rdata, bus.o_dma_rdata}, 64'd0);
    chk("reset_bus", {bus.o_bus_addr, bus.o_bus_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_txn(tbl[i]);

    // Reset lands while a CPU read is waiting for data.
    chk_idle();
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 32'h40;
    bus.i_dma_req = 1'b0; bus.i_bus_data_ready = 1'b0;
    @(negedge clk);
    chk("rst_seq_strobe", {61'd0, bus.o_bus_clk, bus.o_busy, bus.o_owner}, {61'd0, 3'b110});
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctl", {57'd0, bus.o_bus_clk, bus.o_bus_we, bus.o_busy, bus.o_owner,
        bus.o_timeout, bus.o_cpu_ack, bus.o_dma_ack}, 64'd0);
    chk("rst_async_rdata", {bus.o_cpu_rdata, bus.o_dma_rdata}, 64'd0);
    chk("rst_async_bus", {bus.o_bus_addr, bus.o_bus_data}, 64'd0);
    bus.i_cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hold_addr = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_ack", {60'd0, bus.o_cpu_ack, bus.o_dma_ack, bus.o_busy, bus.o_bus_clk}, 64'd0);
    end

    // Randomized traffic; the first round is a forced tie straight after reset.
    m_last = 1'b1;
    m_rd[0] = '0; m_rd[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && (it == 0 || $urandom_range(0, 1) == 1)) begin
          pend[p] = 1'b1;
          pwe[p]  = 1'($urandom_range(0, 1));
          pa[p]   = $urandom;
          pd[p]   = $urandom;
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1; pwe[0] = 1'b0; pa[0] = $urandom; pd[0] = $urandom;
      end
      w   = (pend[0] && pend[1]) ? !m_last : pend[1];
      dly = $urandom_range(0, 6);
      rdd = $urandom;
      eto = 1'b0;
      if (pwe[w]) begin
        lat = 1;
      end else if (dly < TO) begin
        lat = dly + 1;
        m_rd[w] = rdd;
      end else begin
        lat = TO;
        m_rd[w] = '1;
        eto = 1'b1;
      end
      t = mk(pend[0], pwe[0], pa[0], pd[0], pend[1], pwe[1], pa[1], pd[1], dly, rdd, w, lat,
             m_rd[0], m_rd[1], eto);
      do_txn(t);
      m_last  = w;
      pend[w] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter AW, default 32, bus address width.
REQ-002 SHALL have parameter DW, default 32, bus data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum read-wait cycles; 0 disables the timeout.
REQ-004 SHALL have ports as follows; one clock; reset is asynchronous and active-high:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_cpu_req  in  1  CPU request, level, held until ack
- i_cpu_we  in  1  CPU write enable
- i_cpu_addr  in  AW  CPU address
- i_cpu_wdata  in  DW  CPU write data
- o_cpu_ack  out  1  CPU completion pulse
- o_cpu_rdata  out  DW  CPU read data
- i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata, o_dma_ack, o_dma_rdata  same widths and meanings, DMA port
- o_bus_clk  out  1  bus strobe
- o_bus_we  out  1  bus write enable
- o_bus_addr  out  AW  bus address
- o_bus_data  out  DW  bus write data
- i_bus_data  in  DW  bus read data
- i_bus_data_ready  in  1  read-data-valid from memory
- o_busy  out  1  transaction in progress
- o_owner  out  1  0 = CPU, 1 = DMA; valid while o_busy
- o_timeout  out  1  read-timeout pulse

Function
REQ-005 SHALL implement FSM states IDLE, READ_WAIT, WRITE, RELEASE; all outputs registered.
REQ-006 In IDLE with any request, SHALL grant one requester, latch its we/addr/wdata, set o_busy=1, set o_owner, o_bus_clk=1, o_bus_addr=addr, o_bus_we=we.
- On a write, SHALL also set o_bus_data=wdata and go to WRITE.
- On a read, SHALL go to READ_WAIT.
REQ-007 Arbitration SHALL be round-robin: a sole requester is always granted; on simultaneous requests, the requester not granted last wins.
REQ-008 WRITE SHALL last exactly one cycle, then set o_bus_clk=0, o_bus_we=0, o_bus_data=0 and owner ack=1, and go to RELEASE.
REQ-009 In READ_WAIT with i_bus_data_ready=1, SHALL capture i_bus_data into the owner's rdata, set o_bus_clk=0 and owner ack=1, and go to RELEASE.
REQ-010 i_bus_data_ready SHALL be ignored outside READ_WAIT.
REQ-011 Timeout counter behaviour:
- SHALL clear at grant and increment each READ_WAIT cycle without ready.
- When the count equals TIMEOUT_CYCLES-1 with no ready, SHALL abort: rdata=all ones, o_bus_clk=0, ack=1, o_timeout=1 (same cycle as ack), go to RELEASE.
- Ready and timeout in the same cycle: ready wins, no o_timeout.
REQ-012 RELEASE SHALL last one cycle with acks and o_timeout visible, clear them at its end, set o_busy=0, and return to IDLE without arbitrating.
REQ-013 Latency: req sampled in cycle N gives bus strobe in N+1; write ack in N+2; read ack one cycle after the cycle ready is sampled; back-to-back transaction minimum period is 3 cycles.
REQ-014 Requesters SHALL drop req in the cycle after ack; rdata SHALL hold until that port's next read completes.
REQ-015 o_bus_addr SHALL hold its last value when idle; the non-owner's ack SHALL stay 0.

Reset
REQ-016 On i_rst=1, SHALL immediately and asynchronously go to IDLE with o_bus_clk, o_bus_we, o_bus_addr, o_bus_data, acks, rdata, o_busy, o_owner, o_timeout and the counter all 0.
REQ-017 On reset, the last-granted pointer SHALL be DMA, so the CPU wins the first tie.
REQ-018 A transaction interrupted by reset SHALL produce no ack after reset deasserts.

Verification
REQ-019 CPU write addr 0x1234, data 0xA5 -> strobe with o_bus_we=1 for 1 cycle at N+1; o_cpu_ack at N+2; o_dma_ack=0.
REQ-020 DMA read addr 0x0200, ready after 3 wait cycles, data 0xDEADBEEF -> o_dma_rdata=0xDEADBEEF with o_dma_ack one cycle after ready; o_timeout=0.
REQ-021 CPU and DMA request simultaneously from reset, held -> grants alternate CPU, DMA, CPU, each 3 cycles apart minimum.
REQ-022 Read with ready never asserted, TIMEOUT_CYCLES=4 -> ack and o_timeout together; rdata=0xFFFFFFFF; o_bus_clk=0.
REQ-023 Reset asserted during READ_WAIT -> all outputs 0 immediately; no ack after release; next tie goes to CPU.
REQ-024 i_bus_data_ready=1 held while IDLE, then read issued -> ready is ignored in IDLE; data is captured in the first READ_WAIT cycle; ack the following cycle.
